sbox_sub_engine: RTL and testbench
==================================

# sbox_sub_engine

Parametrised successor to the single-table byte-substitution stage. It loads a chaos-generated S-box as a serial byte stream, builds the matching inverse S-box during the load, and checks the table for bijectivity. It then substitutes every lane of a wide data word through either table, one word per cycle. The output is a valid/ready stream with backpressure, and the table can be reloaded at runtime. The block sits between the chaotic S-box generator and the diffusion stage, and serves both the encryption and decryption paths.

## Interface
- `SBOX_WIDTH`, 8: lane/entry width W. Table depth is 2^W.
- `DATA_WIDTH`, 128: data word width. Must be a multiple of `SBOX_WIDTH`. LANES = DATA_WIDTH/SBOX_WIDTH.
- `clk` input 1: single clock.
- `reset` input 1: synchronous, active-high reset.
- `sbox_reload` input 1: single-cycle pulse. Discards the current table and restarts loading.
- `sbox_valid` input 1: a table entry is present on `sbox_out`.
- `sbox_out` input W: table entry. Entries arrive in index order 0..2^W-1.
- `sbox_ready` output 1: table loaded and bijective. The block is in RUN.
- `sbox_error` output 1: the last load contained a duplicate value. The block is in FAIL.
- `s_valid` input 1: input word valid.
- `s_ready` output 1: block accepts the input word this cycle.
- `s_data` input DATA_WIDTH: input word. Lane g is bits `[g*W +: W]`.
- `s_mode` input 1: 0 selects the forward table, 1 selects the inverse table. Sampled with `s_data`.
- `m_valid` output 1: output word valid.
- `m_ready` input 1: downstream accepts the output word.
- `m_data` output DATA_WIDTH: substituted word, lane-aligned with `s_data`.

## Operation
- State machine: LOAD, RUN, FAIL.
- **LOAD.** Each cycle with `sbox_valid`=1, at index `idx` (W bits) with value v:
  - write `fwd[idx] <= v` and `inv[v] <= idx`;
  - if `seen[v]` is already 1, set the sticky `dup` flag;
  - set `seen[v] <= 1`;
  - increment `idx`.
  - On the entry with idx = 2^W-1: go to FAIL if `dup` was already set or this entry is itself a duplicate, otherwise go to RUN. `idx` wraps to 0.
- **RUN.** `sbox_valid` is ignored and the tables are frozen.
- **FAIL.** No data is accepted. `sbox_error`=1 until `sbox_reload` or `reset`.
- **Reload.**
  - `sbox_reload`=1 in any state, next cycle: state LOAD, `idx`=0, `seen`=0, `dup`=0, `sbox_ready`=0, `sbox_error`=0, `m_valid`=0 (the in-flight word is discarded).
  - If `sbox_reload` and `sbox_valid` are asserted together, reload wins and the entry is dropped.
- **Substitution.**
  - Each lane g reads its own replica of the selected table: `fwd[s_data lane g]` or `inv[s_data lane g]`.
  - LANES replicas of each table are kept, each a single-read-port distributed RAM. All replicas are written identically during LOAD.
- **Handshake.**
  - `s_ready` = (state==RUN) && !`sbox_reload` && (!`m_valid` || `m_ready`).
  - A transfer occurs when `s_valid` && `s_ready`. The result is registered into `m_data`/`m_valid`.
  - `m_valid` clears when `m_ready`=1 and no new transfer occurs.
  - `m_data` holds its value while `m_valid`=1 && `m_ready`=0.
- Table RAMs and `seen` are not reset by `reset` (`seen` is cleared on entering LOAD). Contents are undefined until the first load completes.

## Timing
- **Reset values:** state LOAD, `idx`=0, `sbox_ready`=0, `sbox_error`=0, `s_ready`=0, `m_valid`=0, `m_data`=0.
- **Load duration:** 2^W `sbox_valid` cycles (gaps allowed). `sbox_ready` or `sbox_error` rises the cycle after the last entry.
- **Latency:** 1 cycle from accepted input to `m_valid`. Throughput is 1 word/cycle while `m_ready`=1.
- **Back-to-back:** the first word may be accepted in the cycle `sbox_ready` is first high.
- **Mode:** may change every word with no bubble.
- **Reset mid-load:** discards partial tables, restarts at `idx`=0.
- **Reset mid-stream:** `m_valid` drops the next cycle and the held word is lost.

## Test plan
- **Forward load and lookup.** Load `sbox[i]` = (i+1) mod 256, send `s_data`=0x000102…0E0F with mode 0 → one cycle later `m_valid`=1, `m_data`=0x0102…0F10. `sbox_ready` rises exactly 1 cycle after the 256th entry.
- **Inverse lookup.** Same table, `s_data`=0x00FF0000…00 with mode 1 → lanes map 0x00→0xFF and 0xFF→0xFE, giving `m_data`=0xFFFEFFFF…FF. Alternate modes on consecutive cycles and check there are no bubbles.
- **Duplicate detect.** Load `sbox[i]` = i except `sbox[200]`=5 → `sbox_error`=1, `sbox_ready`=0, `s_ready` stays 0 with `s_valid` held high. A later `sbox_reload` plus a valid load → `sbox_error`=0, `sbox_ready`=1.
- **Backpressure.** RUN, `s_valid`=1 every cycle, `m_ready` toggling 1,0,0,1 → no words dropped or duplicated, `m_data` stable while stalled, `s_ready`=0 exactly in the stalled cycles.
- **Reload mid-stream.** Pulse `sbox_reload` with `m_valid`=1, `m_ready`=0 → next cycle `m_valid`=0, `sbox_ready`=0. Reload `sbox[i]` = i XOR 0x63, input 0x00 → all lanes 0x63.
- **Reset priority.** Assert `reset` at `idx`=100 together with `sbox_valid` → all outputs return to reset values. A full 256-entry load afterwards succeeds, verified by lookup of 0xFF.

Source files
------------

// File: rtl/sbox_sub_engine.sv
// Byte-substitution engine: serially loads a forward S-box, builds its inverse on the fly,
// checks bijectivity, then substitutes every lane of a wide word through either table.
`timescale 1ns/1ps

module sbox_sub_engine #(
    parameter int SBOX_WIDTH = 8,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sbox_reload,
    input  logic                  sbox_valid,
    input  logic [SBOX_WIDTH-1:0] sbox_out,
    output logic                  sbox_ready,
    output logic                  sbox_error,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_mode,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);

    localparam int W     = SBOX_WIDTH;
    localparam int DEPTH = 1 << W;
    localparam int LANES = DATA_WIDTH / W;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t                state_q, state_d;
    logic [W-1:0]          idx_q, idx_d;
    logic                  dup_q, dup_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [DEPTH-1:0]      seen_q;
    logic [DATA_WIDTH-1:0] lookup;
    logic                  wr_en;
    logic                  seen_hit;
    logic                  xfer;

    assign wr_en    = (state_q == ST_LOAD) && sbox_valid && !sbox_reload && !reset;
    assign seen_hit = seen_q[sbox_out];
    assign s_ready  = (state_q == ST_RUN) && !sbox_reload && (!m_valid_q || m_ready);
    assign xfer     = s_valid && s_ready;

    // One single-read-port replica of each table per lane so all lanes look up in parallel.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [W-1:0] fwd_mem [DEPTH];
            logic [W-1:0] inv_mem [DEPTH];
            logic [W-1:0] lane_in;

            assign lane_in = s_data[gi*W +: W];

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    fwd_mem[idx_q]    <= sbox_out;
                    inv_mem[sbox_out] <= idx_q;
                end
            end

            assign lookup[gi*W +: W] = s_mode ? inv_mem[lane_in] : fwd_mem[lane_in];
        end
    endgenerate

    // Occupancy map for duplicate detection; emptied whenever loading restarts.
    always_ff @(posedge clk) begin
        if (reset || sbox_reload) begin
            seen_q <= '0;
        end else if (wr_en) begin
            seen_q[sbox_out] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_LOAD;
            idx_q     <= '0;
            dup_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dup_q     <= dup_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dup_d     = dup_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;

        if (xfer) begin
            m_valid_d = 1'b1;
            m_data_d  = lookup;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            ST_LOAD: begin
                if (sbox_valid) begin
                    idx_d = idx_q + W'(1);
                    if (seen_hit) begin
                        dup_d = 1'b1;
                    end
                    if (&idx_q) begin
                        state_d = (dup_q || seen_hit) ? ST_FAIL : ST_RUN;
                    end
                end
            end
            default: ;
        endcase

        // Reload overrides everything, including an entry presented in the same cycle.
        if (sbox_reload) begin
            state_d   = ST_LOAD;
            idx_d     = '0;
            dup_d     = 1'b0;
            m_valid_d = 1'b0;
        end
    end

    assign sbox_ready = (state_q == ST_RUN);
    assign sbox_error = (state_q == ST_FAIL);
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;

endmodule

// File: tb/tb_sbox_sub_engine.sv
// Self-checking bench for sbox_sub_engine: a table/permutation-level model is compared every
// cycle, plus literal expectations taken from hand-worked table lookups.
`timescale 1ns/1ps

module tb_sbox_sub_engine;

    localparam int P_LOAD = 0;
    localparam int P_RUN  = 1;
    localparam int P_FAIL = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         sbox_reload;
    logic         sbox_valid;
    logic [7:0]   sbox_out;
    logic         sbox_ready;
    logic         sbox_error;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic         s_mode;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;

    always #5 clk = ~clk;

    sbox_sub_engine #(.SBOX_WIDTH(8), .DATA_WIDTH(128)) dut (
        .clk        (clk),
        .reset      (reset),
        .sbox_reload(sbox_reload),
        .sbox_valid (sbox_valid),
        .sbox_out   (sbox_out),
        .sbox_ready (sbox_ready),
        .sbox_error (sbox_error),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_mode     (s_mode),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model: the loaded permutation and its inverse, plus the output register.
    int           mphase;
    int           mcnt;
    int           mdistinct;
    bit           mseen [256];
    logic [7:0]   mfwd  [256];
    logic [7:0]   minv  [256];
    logic         exp_mvalid;
    logic [127:0] exp_mdata;
    logic [7:0]   ld_tbl [256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    function automatic logic [127:0] subst(input logic [127:0] d, input logic mode);
        logic [127:0] r;
        r = '0;
        for (int g = 0; g < 16; g++) begin
            r[g*8 +: 8] = mode ? minv[d[g*8 +: 8]] : mfwd[d[g*8 +: 8]];
        end
        return r;
    endfunction

    task automatic clear_model();
        mphase     = P_LOAD;
        mcnt       = 0;
        mdistinct  = 0;
        exp_mvalid = 1'b0;
        for (int i = 0; i < 256; i++) mseen[i] = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                clear_model();
                exp_mdata = '0;
            end else if (sbox_reload) begin
                clear_model();
            end else begin
                if (mphase == P_RUN && s_valid && (!exp_mvalid || m_ready)) begin
                    exp_mdata  = subst(s_data, s_mode);
                    exp_mvalid = 1'b1;
                end else if (m_ready) begin
                    exp_mvalid = 1'b0;
                end
                if (mphase == P_LOAD && sbox_valid) begin
                    mfwd[mcnt]     = sbox_out;
                    minv[sbox_out] = 8'(mcnt);
                    if (!mseen[sbox_out]) mdistinct++;
                    mseen[sbox_out] = 1'b1;
                    mcnt++;
                    if (mcnt == 256) begin
                        mphase = (mdistinct == 256) ? P_RUN : P_FAIL;
                        mcnt   = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check1("sbox_ready", sbox_ready, mphase == P_RUN);
                check1("sbox_error", sbox_error, mphase == P_FAIL);
                check1("m_valid", m_valid, exp_mvalid);
                check1("s_ready", s_ready,
                       (mphase == P_RUN) && !sbox_reload && (!exp_mvalid || m_ready));
                if (exp_mvalid) check("m_data", m_data, exp_mdata);
                if (m_valid && m_ready) $display("out word %h", m_data);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_n(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 7) == 0) begin
                sbox_valid = 1'b0;
                step();
            end
            sbox_valid = 1'b1;
            sbox_out   = ld_tbl[i];
            if (i == 255) check1("ready_before_last", sbox_ready, 1'b0);
            step();
        end
        sbox_valid = 1'b0;
    endtask

    task automatic reload_pulse();
        sbox_reload = 1'b1;
        step();
        sbox_reload = 1'b0;
    endtask

    task automatic send(input logic [127:0] d, input logic mode);
        s_valid = 1'b1;
        s_data  = d;
        s_mode  = mode;
        step();
    endtask

    initial begin
        logic [7:0] tmp;
        int         j;

        reset = 1'b1; sbox_reload = 1'b0; sbox_valid = 1'b0; sbox_out = '0;
        s_valid = 1'b0; s_data = '0; s_mode = 1'b0; m_ready = 1'b1;
        step();
        step();
        chk_en  = 1'b1;
        s_valid = 1'b1;
        #1;
        check1("rst_sbox_ready", sbox_ready, 1'b0);
        check1("rst_sbox_error", sbox_error, 1'b0);
        check1("rst_s_ready", s_ready, 1'b0);
        check1("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 128'h0);
        reset   = 1'b0;
        s_valid = 1'b0;
        step();

        // Forward table sbox[i] = i+1
        for (int i = 0; i < 256; i++) ld_tbl[i] = 8'(i + 1);
        load_n(256, 1'b1);
        check1("fwd_ready_after_load", sbox_ready, 1'b1);
        check1("first_word_ready", s_ready, 1'b1);
        send(128'h000102030405060708090A0B0C0D0E0F, 1'b0);
        check1("fwd_m_valid", m_valid, 1'b1);
        check("fwd_lookup", m_data, 128'h0102030405060708090A0B0C0D0E0F10);
        send(128'h00FF0000000000000000000000000000, 1'b1);
        check("inv_lookup", m_data, 128'hFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFF);
        send(128'h0, 1'b0);
        check("alt_fwd_zero", m_data, {16{8'h01}});
        send(128'h0, 1'b1);
        check1("alt_no_bubble", m_valid, 1'b1);
        check("alt_inv_zero", m_data, {16{8'hFF}});
        s_valid = 1'b0;
        step();
        check1("idle_m_valid", m_valid, 1'b0);

        // Backpressure: m_ready pattern 1,0,0,1
        for (int c = 0; c < 16; c++) begin
            m_ready = (c % 4 == 0) || (c % 4 == 3);
            send({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();

        // Random permutation, random stream with random backpressure
        reload_pulse();
        for (int i = 0; i < 256; i++) ld_tbl[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp       = ld_tbl[i];
            ld_tbl[i] = ld_tbl[j];
            ld_tbl[j] = tmp;
        end
        load_n(256, 1'b1);
        check1("perm_ready", sbox_ready, 1'b1);
        for (int c = 0; c < 300; c++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            s_data  = {$urandom, $urandom, $urandom, $urandom};
            s_mode  = 1'($urandom_range(0, 1));
            step();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();

        // Reload while a word is stalled at the output
        m_ready = 1'b0;
        send(128'h0123456789ABCDEF0123456789ABCDEF, 1'b0);
        s_valid = 1'b0;
        check1("stall_m_valid", m_valid, 1'b1);
        reload_pulse();
        check1("reload_m_valid", m_valid, 1'b0);
        check1("reload_sbox_ready", sbox_ready, 1'b0);
        m_ready = 1'b1;
        for (int i = 0; i < 256; i++) ld_tbl[i] = 8'(i ^ 8'h63);
        load_n(256, 1'b1);
        check1("xor_ready", sbox_ready, 1'b1);
        send(128'h0, 1'b0);
        check("xor_fwd_zero", m_data, {16{8'h63}});
        send(128'h0, 1'b1);
        check("xor_inv_zero", m_data, {16{8'h63}});
        s_valid = 1'b0;
        step();

        // Duplicate entry
        reload_pulse();
        for (int i = 0; i < 256; i++) ld_tbl[i] = 8'(i);
        ld_tbl[200] = 8'd5;
        load_n(256, 1'b0);
        check1("dup_error", sbox_error, 1'b1);
        check1("dup_ready", sbox_ready, 1'b0);
        s_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check1("dup_s_ready", s_ready, 1'b0);
            step();
        end
        check1("dup_m_valid", m_valid, 1'b0);
        s_valid = 1'b0;
        reload_pulse();
        check1("dup_cleared", sbox_error, 1'b0);
        ld_tbl[200] = 8'd200;
        load_n(256, 1'b1);
        check1("dup_recover_error", sbox_error, 1'b0);
        check1("dup_recover_ready", sbox_ready, 1'b1);

        // Reset at idx=100 together with an entry
        reload_pulse();
        for (int i = 0; i < 256; i++) ld_tbl[i] = 8'(255 - i);
        load_n(100, 1'b0);
        sbox_valid = 1'b1;
        sbox_out   = 8'hAA;
        reset      = 1'b1;
        step();
        reset      = 1'b0;
        sbox_valid = 1'b0;
        s_valid    = 1'b1;
        #1;
        check1("rst2_sbox_ready", sbox_ready, 1'b0);
        check1("rst2_sbox_error", sbox_error, 1'b0);
        check1("rst2_s_ready", s_ready, 1'b0);
        check1("rst2_m_valid", m_valid, 1'b0);
        check("rst2_m_data", m_data, 128'h0);
        s_valid = 1'b0;
        step();
        load_n(256, 1'b1);
        check1("rst2_ready", sbox_ready, 1'b1);
        send({16{8'hFF}}, 1'b0);
        check("rst2_fwd_ff", m_data, 128'h0);
        send(128'h0, 1'b1);
        check("rst2_inv_zero", m_data, {16{8'hFF}});
        s_valid = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
